// File: rtl/element_serializer.sv
// Serializes one element record (tag, open/close flag, attribute pairs) into an
// XML tag character stream with valid/ready output flow control.
module element_serializer #(
  parameter int CHAR_W      = 8,
  parameter int TAG_W       = 3,
  parameter int ATTR_TYPE_W = 3,
  parameter int ATTR_VAL_W  = 8,
  parameter int MAX_ATTR    = 7,
  localparam int CNT_W      = $clog2(MAX_ATTR + 1)
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [TAG_W-1:0]       element_tag,
  input  logic                   is_closing_tag,
  input  logic [CNT_W-1:0]       attr_count,
  input  logic                   attr_valid,
  output logic                   attr_ready,
  input  logic [ATTR_TYPE_W-1:0] attribute_type,
  input  logic [ATTR_VAL_W-1:0]  attribute_value,
  output logic [CHAR_W-1:0]      char_o,
  output logic                   char_valid,
  input  logic                   char_ready,
  output logic                   busy,
  output logic                   has_finished,
  output logic                   error
);

  typedef enum logic [3:0] {
    S_IDLE, S_LT, S_SLASH, S_TAGNAME, S_ATTR_FETCH, S_SPACE, S_ANAME,
    S_EQ, S_QUOTE_OPEN, S_DIGITS, S_QUOTE_CLOSE, S_GT, S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [TAG_W-1:0]       tag_q, tag_d;
  logic                   closing_q, closing_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [ATTR_TYPE_W-1:0] atype_q, atype_d;
  logic [2:0][3:0]        dig_q, dig_d;
  logic [1:0]             ndig_q, ndig_d;

  logic       tag_ok, xfer;
  logic [2:0] tag_len, attr_len;
  logic [7:0] ch;

  // Names are right-justified in a 48-bit word; idx 0 is the leftmost character.
  function automatic logic [7:0] name_char(input logic [47:0] name,
                                           input logic [2:0] len,
                                           input logic [2:0] idx);
    logic [2:0] pos;
    pos = len - 3'd1 - idx;
    return name[{pos, 3'b000} +: 8];
  endfunction

  function automatic logic [47:0] tag_name(input logic [TAG_W-1:0] t);
    case (t)
      TAG_W'(1): return 48'("div");
      TAG_W'(2): return 48'("p");
      TAG_W'(3): return 48'("body");
      TAG_W'(4): return 48'("a");
      TAG_W'(5): return 48'("img");
      default:   return '0;
    endcase
  endfunction

  function automatic logic [47:0] attr_name(input logic [ATTR_TYPE_W-1:0] t);
    case (t)
      ATTR_TYPE_W'(1): return 48'("id");
      ATTR_TYPE_W'(2): return 48'("class");
      ATTR_TYPE_W'(3): return 48'("width");
      ATTR_TYPE_W'(4): return 48'("height");
      ATTR_TYPE_W'(5): return 48'("href");
      default:         return '0;
    endcase
  endfunction

  function automatic logic [2:0] tag_length(input logic [TAG_W-1:0] t);
    case (t)
      TAG_W'(1), TAG_W'(5): return 3'd3;
      TAG_W'(3):            return 3'd4;
      default:              return 3'd1;
    endcase
  endfunction

  function automatic logic [2:0] attr_length(input logic [ATTR_TYPE_W-1:0] t);
    case (t)
      ATTR_TYPE_W'(1): return 3'd2;
      ATTR_TYPE_W'(4): return 3'd6;
      ATTR_TYPE_W'(5): return 3'd4;
      default:         return 3'd5;
    endcase
  endfunction

  assign tag_ok   = (tag_q != '0) && (tag_q <= TAG_W'(5));
  assign tag_len  = tag_length(tag_q);
  assign attr_len = attr_length(atype_q);
  assign xfer     = char_valid && char_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      tag_q     <= '0;
      closing_q <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
      atype_q   <= '0;
      dig_q     <= '0;
      ndig_q    <= '0;
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      closing_q <= closing_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      atype_q   <= atype_d;
      dig_q     <= dig_d;
      ndig_q    <= ndig_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    tag_d     = tag_q;
    closing_d = closing_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    atype_d   = atype_q;
    dig_d     = dig_q;
    ndig_d    = ndig_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d   = S_LT;
        tag_d     = element_tag;
        closing_d = is_closing_tag;
        cnt_d     = is_closing_tag ? '0 : attr_count;
      end
      S_LT: if (!tag_ok) state_d = S_DONE;
            else if (xfer) begin
              idx_d   = '0;
              state_d = closing_q ? S_SLASH : S_TAGNAME;
            end
      S_SLASH: if (xfer) state_d = S_TAGNAME;
      S_TAGNAME: if (xfer) begin
        if (idx_q == tag_len - 3'd1) begin
          idx_d   = '0;
          state_d = (cnt_q == '0) ? S_GT : S_ATTR_FETCH;
        end else idx_d = idx_q + 3'd1;
      end
      S_ATTR_FETCH: if (cnt_q == '0) state_d = S_GT;
        else if (attr_valid) begin
          // Invalid types are consumed silently; the fetch simply repeats.
          cnt_d = cnt_q - CNT_W'(1);
          if (attribute_type != '0 && attribute_type <= ATTR_TYPE_W'(5)) begin
            atype_d  = attribute_type;
            dig_d[2] = 4'(attribute_value / ATTR_VAL_W'(100));
            dig_d[1] = 4'((attribute_value / ATTR_VAL_W'(10)) % ATTR_VAL_W'(10));
            dig_d[0] = 4'(attribute_value % ATTR_VAL_W'(10));
            ndig_d   = (attribute_value >= ATTR_VAL_W'(100)) ? 2'd3 :
                       (attribute_value >= ATTR_VAL_W'(10))  ? 2'd2 : 2'd1;
            idx_d    = '0;
            state_d  = S_SPACE;
          end
        end
      S_SPACE: if (xfer) state_d = S_ANAME;
      S_ANAME: if (xfer) begin
        if (idx_q == attr_len - 3'd1) state_d = S_EQ;
        else idx_d = idx_q + 3'd1;
      end
      S_EQ: if (xfer) state_d = S_QUOTE_OPEN;
      S_QUOTE_OPEN: if (xfer) begin
        idx_d   = {1'b0, ndig_q} - 3'd1;
        state_d = S_DIGITS;
      end
      S_DIGITS: if (xfer) begin
        if (idx_q == '0) state_d = S_QUOTE_CLOSE;
        else idx_d = idx_q - 3'd1;
      end
      S_QUOTE_CLOSE: if (xfer) state_d = (cnt_q == '0) ? S_GT : S_ATTR_FETCH;
      S_GT:   if (xfer) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ch           = 8'h00;
    char_valid   = 1'b1;
    attr_ready   = 1'b0;
    busy         = (state_q != S_IDLE);
    has_finished = (state_q == S_DONE);
    error        = (state_q == S_DONE) && !tag_ok;
    case (state_q)
      S_LT:          begin ch = "<"; char_valid = tag_ok; end
      S_SLASH:       ch = "/";
      S_TAGNAME:     ch = name_char(tag_name(tag_q), tag_len, idx_q);
      S_SPACE:       ch = " ";
      S_ANAME:       ch = name_char(attr_name(atype_q), attr_len, idx_q);
      S_EQ:          ch = "=";
      S_QUOTE_OPEN,
      S_QUOTE_CLOSE: ch = 8'h22;
      S_DIGITS:      ch = 8'h30 + {4'h0, dig_q[idx_q[1:0]]};
      S_GT:          ch = ">";
      S_ATTR_FETCH:  begin char_valid = 1'b0; attr_ready = (cnt_q != '0); end
      default:       char_valid = 1'b0;
    endcase
  end

  assign char_o = CHAR_W'(ch);

endmodule

// File: tb/tb_element_serializer.sv
// Table-driven bench for element_serializer: expected characters go into a
// scoreboard queue at start and are popped as the DUT transfers characters.
module tb_element_serializer;

  logic       clock = 1'b0;
  logic       resetn;
  logic       start = 1'b0;
  logic [2:0] element_tag = '0;
  logic       is_closing_tag = 1'b0;
  logic [2:0] attr_count = '0;
  logic       attr_valid = 1'b0;
  logic       attr_ready;
  logic [2:0] attribute_type = '0;
  logic [7:0] attribute_value = '0;
  logic [7:0] char_o;
  logic       char_valid;
  logic       char_ready = 1'b1;
  logic       busy, has_finished, error;

  always #5 clock = ~clock;

  element_serializer dut (
    .clock(clock), .resetn(resetn), .start(start), .element_tag(element_tag),
    .is_closing_tag(is_closing_tag), .attr_count(attr_count),
    .attr_valid(attr_valid), .attr_ready(attr_ready),
    .attribute_type(attribute_type), .attribute_value(attribute_value),
    .char_o(char_o), .char_valid(char_valid), .char_ready(char_ready),
    .busy(busy), .has_finished(has_finished), .error(error)
  );

  typedef struct {
    logic [2:0] tag;
    bit         closing;
    logic [2:0] cnt;
    int         npairs;
    logic [2:0] t0, t1;
    logic [7:0] v0, v1;
    bit         toggle;
    int         adelay;
    bit         mid_start;
    bit         err;
    string      exp;
  } vec_t;

  int n_pass = 0, n_total = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  byte unsigned sb[$];
  int  hs, xfers, stall, first_xfer_cyc, last_xfer_cyc, done_cyc, done_cnt, start_cyc;
  bit  done_err, hold_pending, hs_now;
  logic [7:0] held;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic clear_stats();
    hs = 0; xfers = 0; stall = 0; first_xfer_cyc = -1; last_xfer_cyc = -1;
    done_cyc = -1; done_cnt = 0; done_err = 0; hold_pending = 0; hs_now = 0;
  endtask

  // Called at the falling edge: scoreboard pops, hold-stability and fetch-stall checks.
  task automatic observe();
    byte unsigned e;
    if (hold_pending) begin
      check("char_hold_valid", char_valid, 1);
      check("char_hold_value", char_o, held);
    end
    hold_pending = char_valid && !char_ready;
    held = char_o;
    if (char_valid && char_ready) begin
      if (sb.size() == 0) check("char_extra", char_valid, 0);
      else begin
        e = sb.pop_front();
        check("char", char_o, e);
      end
      xfers++;
      if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
      last_xfer_cyc = cyc;
    end
    hs_now = attr_valid && attr_ready;
    if (hs_now) hs++;
    if (attr_ready && !attr_valid) begin
      stall++;
      check("valid_low_while_fetching", char_valid, 0);
    end
    if (has_finished) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = error;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int pi;
    clear_stats();
    for (int i = 0; i < v.exp.len(); i++) sb.push_back(v.exp[i]);
    @(posedge clock); #1;
    start = 1; element_tag = v.tag; is_closing_tag = v.closing; attr_count = v.cnt;
    start_cyc = cyc;
    char_ready = 1;
    pi = 0;
    if (v.closing) begin attr_valid = 1; attribute_type = 3'd1; attribute_value = 8'd1; end
    for (int k = 0; k < 300 && done_cnt == 0; k++) begin
      if (!v.closing && pi < v.npairs && !attr_valid && stall >= v.adelay) begin
        attr_valid = 1;
        attribute_type  = (pi == 0) ? v.t0 : v.t1;
        attribute_value = (pi == 0) ? v.v0 : v.v1;
      end
      @(negedge clock);
      observe();
      @(posedge clock); #1;
      start = (v.mid_start && cyc == start_cyc + 2);
      if (start) element_tag = 3'd3;
      if (v.toggle) char_ready = ~char_ready;
      if (hs_now && !v.closing) begin pi++; attr_valid = 0; stall = 0; end
    end
    attr_valid = 0;
    start = 0;
    check("finished_once", done_cnt, 1);
    check("error_flag", done_err, v.err);
    check("scoreboard_empty", sb.size(), 0);
    check("attr_handshakes", hs, v.closing ? 0 : v.npairs);
    if (v.exp.len() > 0) check("finish_after_last_char", done_cyc, last_xfer_cyc + 1);
    else begin
      check("finish_at_start_plus_2", done_cyc, start_cyc + 2);
      check("no_chars", xfers, 0);
    end
    if (!v.toggle && v.exp.len() > 0) check("first_char_latency", first_xfer_cyc, start_cyc + 1);
    @(negedge clock);
    check("finish_pulse_width", has_finished, 0);
    check("error_pulse_width", error, 0);
    check("idle_after_done", busy, 0);
    sb.delete();
    char_ready = 1;
  endtask

  function automatic vec_t mk(input logic [2:0] tag, input bit closing, input logic [2:0] cnt,
                              input int np, input logic [2:0] t0, input logic [7:0] v0,
                              input logic [2:0] t1, input logic [7:0] v1, input bit toggle,
                              input int adelay, input bit mid, input bit err, input string exp);
    vec_t v;
    v.tag = tag; v.closing = closing; v.cnt = cnt; v.npairs = np;
    v.t0 = t0; v.v0 = v0; v.t1 = t1; v.v1 = v1; v.toggle = toggle;
    v.adelay = adelay; v.mid_start = mid; v.err = err; v.exp = exp;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_char"}, char_o, 0);
    check({tag, "_char_valid"}, char_valid, 0);
    check({tag, "_attr_ready"}, attr_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_has_finished"}, has_finished, 0);
    check({tag, "_error"}, error, 0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = mk(3'd1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "<div>");
    vecs[1] = mk(3'd3, 1, 3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, "</body>");
    vecs[2] = mk(3'd5, 0, 3'd2, 2, 3'd3, 8'd120, 3'd1, 8'd0, 0, 0, 0, 0,
                 "<img width=\"120\" id=\"0\">");
    vecs[3] = mk(3'd2, 0, 3'd1, 1, 3'd2, 8'd7, 0, 0, 1, 4, 0, 0, "<p class=\"7\">");
    vecs[4] = mk(3'd0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "");
    vecs[5] = mk(3'd4, 0, 3'd2, 2, 3'd7, 8'd9, 3'd5, 8'd255, 0, 0, 0, 0, "<a href=\"255\">");
    vecs[6] = mk(3'd6, 0, 3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "");
    vecs[7] = mk(3'd1, 0, 3'd1, 1, 3'd4, 8'd45, 0, 0, 0, 0, 0, 0, "<div height=\"45\">");

    resetn = 0;
    #12;
    check_reset_outputs("reset");
    @(negedge clock);
    resetn = 1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset after "<di": outputs drop at once and the tag never finishes.
    clear_stats();
    sb.push_back("<"); sb.push_back("d"); sb.push_back("i");
    @(posedge clock); #1;
    start = 1; element_tag = 3'd1; is_closing_tag = 0; attr_count = 3'd0;
    @(negedge clock); observe();
    @(posedge clock); #1; start = 0;
    for (int k = 0; k < 20 && xfers < 3; k++) begin
      @(negedge clock); observe();
    end
    check("chars_before_reset", xfers, 3);
    #2 resetn = 0;
    #1 check_reset_outputs("mid_reset");
    repeat (2) begin @(negedge clock); observe(); end
    check("no_finish_in_reset", done_cnt, 0);
    resetn = 1;
    run_vec(mk(3'd2, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "<p>"));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
